move_stack_recorder: RTL and testbench
======================================

// Module: move_stack_recorder
// PURPOSE
//  Collects the solver's move sequence into the packed solution vector read by the
//  display/IO stage.
//  - Push/pop interface, so the solver can append moves and back out of dead ends.
//  - On the solver's `solved` strobe, freezes the vector and raises `comp`, so the
//    display stage can step through the moves.
//  - Move 0 is held in ord[1:0], move k in ord[2k+1:2k].
// PARAMETERS
//  MAX_MOVES  17  Moves held in the stack (depth); ord width = 2*MAX_MOVES.
//  CW         5   Count width; must satisfy 2**CW > MAX_MOVES.
// PORTS
//  clk         in   1            clock
//  rst_n       in   1            reset, synchronous, active-low
//  clear       in   1            synchronous restart; same effect as reset
//  push_valid  in   1            solver offers push_move this cycle
//  push_move   in   2            direction code (shared UP/DOWN/RIGHT/LEFT encoding); stored opaquely
//  push_ready  out  1            stack accepts a push this cycle
//  pop         in   1            remove top move (backtrack)
//  solved      in   1            one-cycle strobe: search finished
//  ord         out  2*MAX_MOVES  packed moves; unused slots are 0
//  count       out  CW           number of moves stored
//  comp        out  1            solution frozen and valid
//  overflow    out  1            a push was attempted while full (sticky)
// BEHAVIOUR
//  Reset / clear
//   - States: REC, DONE, ERR.
//   - rst_n=0 or clear=1 forces state REC and ord=0, count=0, comp=0, overflow=0.
//   - clear has priority over every other input.
//  Outputs
//   - All outputs are registered except push_ready.
//   - push_ready = (state==REC) && (count<MAX_MOVES); it is combinational.
//  REC state
//   - push only (push accepted): ord[2*count+:2] <= push_move; count <= count+1.
//     Visible the next cycle.
//   - pop only, count>0: ord[2*(count-1)+:2] <= 0; count <= count-1.
//   - pop with count==0: ignored; no error.
//   - push accepted and pop in the same cycle, count>0: replace the top.
//     ord[2*(count-1)+:2] <= push_move; count is unchanged.
//   - push accepted and pop in the same cycle, count==0: treated as push only.
//   - push_valid=1 while count==MAX_MOVES and no pop: state -> ERR, overflow <= 1,
//     ord and count are unchanged.
//   - With pop also asserted in that case: it is a replace, not an error.
//   - solved=1: state -> DONE and comp <= 1 on the next edge.
//     A push, pop or replace in the same cycle is applied first, so it is included
//     in the frozen result.
//   - solved with count==0: DONE with comp=1 and count=0 (start state is already
//     the goal).
//  DONE state
//   - push, pop and solved are ignored; push_ready=0.
//   - ord, count and comp hold until clear or reset.
//  ERR state
//   - comp=0, overflow=1, push_ready=0; all inputs except clear are ignored.
//  Invariants
//   - ord bits at and above 2*count are always 0.
//   - count never exceeds MAX_MOVES.
// TESTING
//  1. Reset, then push UP, LEFT, DOWN on consecutive cycles, then pulse solved.
//     -> count=3; ord[5:0] = {DOWN, LEFT, UP}; comp=1 one cycle after solved.
//  2. Push 3 moves, pop twice, push RIGHT.
//     -> count=2; ord[3:2]=RIGHT; ord[5:4]=0; ord[33:4]=0.
//  3. Push 17 moves, then hold push_valid=1.
//     -> push_ready=0 at count=17; next cycle overflow=1, ord unchanged, comp stays 0
//        after solved.
//  4. At count=17, assert push_valid=LEFT together with pop.
//     -> ord[33:32]=LEFT, count=17, overflow=0.
//  5. Assert pop at count=0, then solved.
//     -> count=0, comp=1, ord=0.
//     Then push in DONE -> ignored.
//  6. Assert clear mid-sequence (count=5) in the same cycle as push and solved.
//     -> next cycle count=0, ord=0, comp=0, push_ready=1.
//     Repeat the check with rst_n=0.

Source files
------------

// File: rtl/move_stack_recorder.sv
// Push/pop stack of 2-bit solver moves, packed into ord for the display stage.
// Freezes on solved; a push into a full stack without pop latches ERR.
module move_stack_recorder #(
  parameter int MAX_MOVES = 17,
  parameter int CW        = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push_valid,
  input  logic [1:0]             push_move,
  output logic                   push_ready,
  input  logic                   pop,
  input  logic                   solved,
  output logic [2*MAX_MOVES-1:0] ord,
  output logic [CW-1:0]          count,
  output logic                   comp,
  output logic                   overflow
);

  typedef enum logic [1:0] {
    REC,
    DONE,
    ERR
  } state_t;

  localparam logic [CW-1:0] FULL = CW'(MAX_MOVES);

  state_t        state;
  logic          rec;
  logic          empty;
  logic          full;
  logic          do_rep;
  logic          do_push;
  logic          do_pop;
  logic          do_err;
  logic          wr_en;
  logic [CW-1:0] wr_slot;
  logic [1:0]    wr_val;

  always_comb begin
    rec     = (state == REC);
    empty   = (count == '0);
    full    = (count == FULL);
    // push+pop on a non-empty stack replaces the top, even when full
    do_rep  = rec && push_valid && pop && !empty;
    do_push = rec && push_valid && !full && !do_rep;
    do_err  = rec && push_valid && full && !pop;
    do_pop  = rec && pop && !push_valid && !empty;
    wr_en   = do_rep || do_push || do_pop;
    wr_slot = do_push ? count : count - 1'b1;
    wr_val  = do_pop ? 2'b00 : push_move;
  end

  assign push_ready = rec && !full;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state    <= REC;
      ord      <= '0;
      count    <= '0;
      comp     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      for (int i = 0; i < MAX_MOVES; i++) begin
        if (wr_en && wr_slot == CW'(i))
          ord[2*i +: 2] <= wr_val;
      end
      if (do_push)
        count <= count + 1'b1;
      else if (do_pop)
        count <= count - 1'b1;
      if (do_err) begin
        state    <= ERR;
        overflow <= 1'b1;
      end else if (rec && solved) begin
        state <= DONE;
        comp  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_move_stack_recorder.sv
// Directed and random checks of move_stack_recorder against a queue model.
// Inputs change #1 after posedge; outputs are checked #1 after each edge.
module tb_move_stack_recorder;

  localparam int MAXM = 17;
  localparam int CW   = 5;
  localparam logic [1:0] UP    = 2'd0;
  localparam logic [1:0] DOWN  = 2'd1;
  localparam logic [1:0] RIGHT = 2'd2;
  localparam logic [1:0] LEFT  = 2'd3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clear;
  logic            push_valid;
  logic [1:0]      push_move;
  logic            push_ready;
  logic            pop;
  logic            solved;
  logic [2*MAXM-1:0] ord;
  logic [CW-1:0]   count;
  logic            comp;
  logic            overflow;

  int n_assert = 0;
  int n_fail   = 0;

  // model: 0 recording, 1 done, 2 error
  logic [1:0] q[$];
  int         m_st;
  logic       m_comp;
  logic       m_ovf;

  always #5 clk = ~clk;

  move_stack_recorder #(.MAX_MOVES(MAXM), .CW(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .push_valid(push_valid),
    .push_move(push_move),
    .push_ready(push_ready),
    .pop(pop),
    .solved(solved),
    .ord(ord),
    .count(count),
    .comp(comp),
    .overflow(overflow)
  );

  function automatic logic [63:0] m_ord();
    logic [63:0] o;
    o = '0;
    foreach (q[i]) o[2*i +: 2] = q[i];
    return o;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (!rst_n || clear) begin
      q.delete();
      m_st   = 0;
      m_comp = 1'b0;
      m_ovf  = 1'b0;
    end else if (m_st == 0) begin
      if (push_valid && pop && q.size() > 0)
        q[q.size()-1] = push_move;
      else if (push_valid && q.size() < MAXM)
        q.push_back(push_move);
      else if (push_valid && !pop)
        m_st = 2;
      else if (pop && q.size() > 0)
        void'(q.pop_back());
      if (m_st == 2)
        m_ovf = 1'b1;
      else if (solved) begin
        m_st   = 1;
        m_comp = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ord"}, 64'(ord), m_ord());
    chk({tag, ".count"}, 64'(count), 64'(q.size()));
    chk({tag, ".comp"}, 64'(comp), 64'(m_comp));
    chk({tag, ".overflow"}, 64'(overflow), 64'(m_ovf));
    chk({tag, ".push_ready"}, 64'(push_ready),
        64'(m_st == 0 && q.size() < MAXM));
  endtask

  task automatic idle();
    rst_n = 1'b1; clear = 1'b0; push_valid = 1'b0;
    push_move = 2'd0; pop = 1'b0; solved = 1'b0;
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
    idle();
  endtask

  task automatic do_push(input logic [1:0] mv, input string tag);
    push_valid = 1'b1;
    push_move  = mv;
    tick(tag);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick("clr");
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    tick("reset");
    chk("reset.count0", 64'(count), 64'd0);

    // 1: three pushes then solved
    do_push(UP, "t1.p0");
    do_push(LEFT, "t1.p1");
    do_push(DOWN, "t1.p2");
    solved = 1'b1;
    tick("t1.solved");
    chk("t1.ord5_0", 64'(ord[5:0]), 64'({DOWN, LEFT, UP}));
    chk("t1.comp", 64'(comp), 64'd1);

    // 2: push 3, pop 2, push RIGHT
    do_clear();
    do_push(UP, "t2.p0");
    do_push(DOWN, "t2.p1");
    do_push(LEFT, "t2.p2");
    pop = 1'b1; tick("t2.pop0");
    pop = 1'b1; tick("t2.pop1");
    do_push(RIGHT, "t2.p3");
    chk("t2.top", 64'(ord[3:2]), 64'(RIGHT));
    chk("t2.upper", 64'(ord[33:4]), 64'd0);
    chk("t2.count", 64'(count), 64'd2);

    // 3: fill, then push while full
    do_clear();
    for (int i = 0; i < MAXM; i++)
      do_push(2'(i), "t3.fill");
    chk("t3.ready_full", 64'(push_ready), 64'd0);
    do_push(RIGHT, "t3.ovf");
    chk("t3.overflow", 64'(overflow), 64'd1);
    solved = 1'b1;
    tick("t3.solved");
    chk("t3.comp", 64'(comp), 64'd0);

    // 4: replace at full
    do_clear();
    for (int i = 0; i < MAXM; i++)
      do_push(2'(i + 1), "t4.fill");
    push_valid = 1'b1; push_move = LEFT; pop = 1'b1;
    tick("t4.rep");
    chk("t4.top", 64'(ord[33:32]), 64'(LEFT));
    chk("t4.count", 64'(count), 64'd17);

    // 5: pop on empty, solve empty, push in DONE
    do_clear();
    pop = 1'b1; tick("t5.pop_empty");
    solved = 1'b1; tick("t5.solved");
    chk("t5.comp", 64'(comp), 64'd1);
    do_push(UP, "t5.push_done");
    pop = 1'b1; tick("t5.pop_done");

    // 6: clear and reset override push+solved at count=5
    do_clear();
    for (int i = 0; i < 5; i++) do_push(RIGHT, "t6.fill");
    clear = 1'b1; push_valid = 1'b1; push_move = UP; solved = 1'b1;
    tick("t6.clear");
    chk("t6.ready", 64'(push_ready), 64'd1);
    for (int i = 0; i < 5; i++) do_push(LEFT, "t6.fill2");
    rst_n = 1'b0; push_valid = 1'b1; push_move = UP; solved = 1'b1;
    tick("t6.rst");
    chk("t6.count", 64'(count), 64'd0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      push_valid = ($urandom_range(0, 99) < 60);
      push_move  = 2'($urandom_range(0, 3));
      pop        = ($urandom_range(0, 99) < 30);
      solved     = ($urandom_range(0, 99) < 3);
      clear      = ($urandom_range(0, 99) < 3);
      rst_n      = ($urandom_range(0, 199) != 0);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
